// File: rtl/pio_in_pkg.sv
// Shared constants for the key/edge input PIO: register map, edge selection codes
// and the debounce counter width helper.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // A 1-bit floor keeps the counter declarable when debouncing is disabled.
  function automatic int cnt_width(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// One input bit: two-flop synchroniser, consecutive-stable-cycle counter and accepted level,
// with single-cycle rise/fall pulses aligned to the cycle the accepted level changes.
module pio_in_debounce
  import pio_in_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_stable,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);

  logic r_sync1;
  logic r_sync2;
  logic r_stable;
  logic w_accept;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= IDLE_LEVEL;
      r_sync2 <= IDLE_LEVEL;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES <= 1) begin : g_nodeb
      assign w_accept = (r_sync2 != r_stable);
    end else begin : g_deb
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] r_cnt;

      assign w_accept = (r_sync2 != r_stable) && (r_cnt == LAST);

      // Any return to the accepted level restarts the count from zero.
      always_ff @(posedge clk) begin
        if (!reset_n || (r_sync2 == r_stable) || w_accept) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stable <= IDLE_LEVEL;
    end else if (w_accept) begin
      r_stable <= r_sync2;
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = w_accept &  r_sync2;
  assign o_fall   = w_accept & ~r_sync2;

endmodule

// File: rtl/pio_key_edge_in.sv
// Avalon-MM input PIO for debounced keys: data/irqmask/edgecapture registers and a level irq
// raised by unmasked captured edges.
module pio_key_edge_in
  import pio_in_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic             w_write;
  logic             w_unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_in_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_LEVEL      (IDLE_LEVEL[0])
      ) u_deb (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_pin    (in_port[gi]),
        .o_stable (w_stable[gi]),
        .o_rise   (w_rise[gi]),
        .o_fall   (w_fall[gi])
      );
    end
  endgenerate

  assign w_event = (EDGE_TYPE == EDGE_RISING)  ? w_rise :
                   (EDGE_TYPE == EDGE_FALLING) ? w_fall : (w_rise | w_fall);

  assign w_write        = chipselect & ~write_n;
  assign w_clr          = (w_write && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  assign w_unused_wdata = &{1'b0, writedata};

  // Event OR-ed after the clear so a same-cycle capture survives a clear write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      if (w_write && address == ADDR_IRQMASK) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
      r_edgecap <= (r_edgecap & ~w_clr) | w_event;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = w_stable;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edgecap;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_pio_key_edge_in.sv
// Directed bench for pio_key_edge_in (WIDTH=4, DEBOUNCE_CYCLES=4, falling edges, idle high);
// expected values go into a scoreboard queue as stimulus is driven and are popped at each check.
module tb_pio_key_edge_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  in_port = 4'hF;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  pio_key_edge_in #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .EDGE_TYPE       (1),
    .IDLE_LEVEL      (1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic push_exp(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty: observed %0h with no expected entry", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, e);
    end
  endtask

  task automatic rd(input string t, input logic [1:0] a, input logic [31:0] v);
    push_exp(t, v);
    address = a;
    #1;
    pop_check(readdata);
  endtask

  task automatic chk_irq(input string t, input logic v);
    push_exp(t, {31'b0, v});
    #1;
    pop_check({31'b0, irq});
  endtask

  initial begin
    // 1. reset state
    tick(3);
    reset_n = 1'b1;
    tick(1);
    rd("rst_data", 2'd0, 32'hF);
    rd("rst_mask", 2'd2, 32'h0);
    rd("rst_edge", 2'd3, 32'h0);
    rd("rst_rsvd", 2'd1, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // writes to data and reserved addresses have no effect
    wr(2'd0, 32'h0);
    wr(2'd1, 32'hFFFF_FFFF);
    rd("wr0_ignored", 2'd0, 32'hF);
    rd("wr1_ignored", 2'd1, 32'h0);

    // 2. falling edge on bit 0: visible on the 6th edge after the change, not the 5th
    in_port = 4'hE;
    tick(5);
    rd("lat5_data", 2'd0, 32'hF);
    rd("lat5_edge", 2'd3, 32'h0);
    tick(1);
    rd("lat6_data", 2'd0, 32'hE);
    rd("lat6_edge", 2'd3, 32'h1);
    wr(2'd3, 32'h1);
    rd("clr_edge", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(10);
    rd("rise_data", 2'd0, 32'hF);
    rd("rise_not_cap", 2'd3, 32'h0);

    // 3. 3-cycle glitch is rejected, 4-cycle low is accepted
    in_port = 4'hE;
    tick(3);
    in_port = 4'hF;
    tick(10);
    rd("glitch_data", 2'd0, 32'hF);
    rd("glitch_edge", 2'd3, 32'h0);
    in_port = 4'hE;
    tick(4);
    in_port = 4'hF;
    tick(10);
    rd("pulse4_edge", 2'd3, 32'h1);
    rd("pulse4_data", 2'd0, 32'hF);
    wr(2'd3, 32'hF);
    rd("clr_all", 2'd3, 32'h0);

    // 4. mask, irq, write-1-to-clear per bit
    wr(2'd2, 32'h1);
    rd("mask_rd", 2'd2, 32'h1);
    chk_irq("irq_idle", 1'b0);
    in_port = 4'hE;
    tick(8);
    chk_irq("irq_set", 1'b1);
    wr(2'd3, 32'h2);
    chk_irq("irq_wrong_clr", 1'b1);
    rd("edge_after_w2", 2'd3, 32'h1);
    wr(2'd3, 32'h1);
    chk_irq("irq_cleared", 1'b0);
    rd("edge_after_w1", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(10);

    // 5. clear on the same cycle as the capture event: capture wins
    in_port = 4'hE;
    tick(5);
    wr(2'd3, 32'h1);
    rd("set_wins_edge", 2'd3, 32'h1);
    chk_irq("set_wins_irq", 1'b1);
    wr(2'd2, 32'h0);
    chk_irq("masked_irq", 1'b0);
    rd("masked_edge", 2'd3, 32'h1);
    wr(2'd3, 32'h1);
    in_port = 4'hF;
    tick(10);

    // 6. bit 3 falls, reset lands mid-count, pin stays low
    in_port = 4'h7;
    tick(4);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    rd("rst2_data", 2'd0, 32'hF);
    rd("rst2_edge", 2'd3, 32'h0);
    tick(5);
    rd("post5_data", 2'd0, 32'hF);
    rd("post5_edge", 2'd3, 32'h0);
    tick(1);
    rd("post6_data", 2'd0, 32'h7);
    rd("post6_edge", 2'd3, 32'h8);

    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: %0d entries unchecked", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
